// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks the destination registers of the instructions between decode and
//   write-back (entry 0 = EX ... entry DEPTH-1 = WB). From these it decides,
//   for each decode source operand, whether the operand can be forwarded or
//   whether decode has to stall.
//
//   Build option: define SCOREBOARD_FWD_EN to enable forwarding. When it is
//   not defined, fwd_sel_o is always 0 and any in-flight writer of a source
//   register stalls decode until that writer retires.
//
// Ports
//   CLK             clock, rising edge
//   nRST            asynchronous active-low reset
//   advance_i       pipeline advances this cycle
//   flush_i         taken branch/jump; squash the youngest in-flight entry
//   dec_valid_i     decode slot holds a real instruction
//   dec_wen_i       decode instruction writes a register
//   dec_wsel_i      decode destination register
//   dec_load_i      decode instruction is a load
//   dec_src_i       packed decode sources, source s at [s*RW +: RW]
//   dec_src_used_i  per-source "operand is read" flags
//   stall_o         hold fetch/decode and inject a bubble
//   fwd_sel_o       per source: 0 = register file, k = result of entry k-1
//   stall_cnt_o     saturating count of stalled advancing cycles
module hazard_scoreboard #(
  parameter  int DEPTH = 3,
  parameter  int NSRC  = 2,
  parameter  int RW    = 5,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                advance_i,
  input  logic                flush_i,
  input  logic                dec_valid_i,
  input  logic                dec_wen_i,
  input  logic [RW-1:0]       dec_wsel_i,
  input  logic                dec_load_i,
  input  logic [NSRC*RW-1:0]  dec_src_i,
  input  logic [NSRC-1:0]     dec_src_used_i,
  output logic                stall_o,
  output logic [NSRC*SW-1:0]  fwd_sel_o,
  output logic [15:0]         stall_cnt_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] load_q, load_d;
  logic [RW-1:0]    wsel_q [DEPTH];
  logic [RW-1:0]    wsel_d [DEPTH];
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0]  haz;
  logic             insertable;

  // Per-source match search. The loop runs from the oldest entry to the
  // youngest so the last hit seen is the youngest writer.
  always_comb begin
    logic [RW-1:0] src;
    logic          hit;
`ifdef SCOREBOARD_FWD_EN
    int            hit_idx;
    logic          hit_load;
`endif
    haz       = '0;
    fwd_sel_o = '0;
    for (int s = 0; s < NSRC; s++) begin
      src = dec_src_i[s*RW +: RW];
      hit = 1'b0;
`ifdef SCOREBOARD_FWD_EN
      hit_idx  = 0;
      hit_load = 1'b0;
`endif
      if (dec_src_used_i[s] && (src != '0)) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (valid_q[i] && (wsel_q[i] == src)) begin
            hit = 1'b1;
`ifdef SCOREBOARD_FWD_EN
            hit_idx  = i;
            hit_load = load_q[i];
`endif
          end
        end
      end
`ifdef SCOREBOARD_FWD_EN
      // A load still in EX has no data yet: load-use bubble.
      if (hit) begin
        if ((hit_idx == 0) && hit_load) haz[s] = 1'b1;
        else fwd_sel_o[s*SW +: SW] = SW'(hit_idx + 1);
      end
`else
      haz[s] = hit;
`endif
    end
    stall_o = |haz;
  end

`ifndef SCOREBOARD_FWD_EN
  // Without forwarding the load flag of the oldest entry is never consulted.
  logic unused_load;
  assign unused_load = load_q[DEPTH-1];
`endif

  assign insertable = dec_valid_i & dec_wen_i & (dec_wsel_i != '0);

  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    wsel_d  = wsel_q;
    if (flush_i || advance_i) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        load_d[i]  = load_q[i-1];
        wsel_d[i]  = wsel_q[i-1];
      end
      valid_d[0] = 1'b0;
      load_d[0]  = 1'b0;
      wsel_d[0]  = '0;
      if (flush_i) begin
        // Old entry 0 lands in entry 1 and is squashed there; flush also
        // overrides any stall, so decode is never inserted.
        valid_d[1] = 1'b0;
        load_d[1]  = 1'b0;
        wsel_d[1]  = '0;
      end else if (insertable && !stall_o) begin
        valid_d[0] = 1'b1;
        load_d[0]  = dec_load_i;
        wsel_d[0]  = dec_wsel_i;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && advance_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q     <= '0;
      load_q      <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) wsel_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      load_q      <= load_d;
      wsel_q      <= wsel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        advance_i, flush_i;
  logic        dec_valid_i, dec_wen_i, dec_load_i;
  logic [4:0]  dec_wsel_i;
  logic [9:0]  dec_src_i;
  logic [1:0]  dec_src_used_i;
  logic        stall_o;
  logic [3:0]  fwd_sel_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.DEPTH(3), .NSRC(2), .RW(5)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .advance_i      (advance_i),
    .flush_i        (flush_i),
    .dec_valid_i    (dec_valid_i),
    .dec_wen_i      (dec_wen_i),
    .dec_wsel_i     (dec_wsel_i),
    .dec_load_i     (dec_load_i),
    .dec_src_i      (dec_src_i),
    .dec_src_used_i (dec_src_used_i),
    .stall_o        (stall_o),
    .fwd_sel_o      (fwd_sel_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic dec(input logic v, input logic w, input logic [4:0] ws, input logic ld);
    dec_valid_i = v;
    dec_wen_i   = w;
    dec_wsel_i  = ws;
    dec_load_i  = ld;
  endtask

  task automatic src(input logic [4:0] s0, input logic u0, input logic [4:0] s1, input logic u1);
    dec_src_i      = {s1, s0};
    dec_src_used_i = {u1, u0};
  endtask

  initial begin
    nRST = 1'b0;
    advance_i = 1'b0;
    flush_i = 1'b0;
    dec(0, 0, 0, 0);
    src(0, 0, 0, 0);
    #3;
    chk("rst_stall", stall_o, 0);
    chk("rst_fwd", fwd_sel_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    #9;
    nRST = 1'b1;
    advance_i = 1'b1;

`ifdef SCOREBOARD_FWD_EN
    // add r3 moving through the pipe
    dec(1, 1, 3, 0); step();
    dec(1, 0, 0, 0); src(3, 1, 0, 0); #1;
    chk("r3_e0_fwd", fwd_sel_o, 4'h1);
    chk("r3_e0_stall", stall_o, 0);
    step(); chk("r3_e1_fwd", fwd_sel_o, 4'h2);
    step(); chk("r3_e2_fwd", fwd_sel_o, 4'h3);
    step(); chk("r3_retired_fwd", fwd_sel_o, 4'h0);

    // lw r5 load-use
    src(0, 0, 0, 0); dec(1, 1, 5, 1); step();
    dec(1, 0, 0, 0); src(0, 0, 5, 1); #1;
    chk("lw_stall", stall_o, 1);
    chk("lw_stall_fwd", fwd_sel_o, 0);
    advance_i = 1'b0; step();
    chk("lw_hold_stall", stall_o, 1);
    chk("lw_hold_cnt", stall_cnt_o, 0);
    advance_i = 1'b1; step();
    chk("lw_after_stall", stall_o, 0);
    chk("lw_after_fwd", fwd_sel_o, 4'h8);
    chk("lw_after_cnt", stall_cnt_o, 1);
    step(); chk("lw_e2_fwd", fwd_sel_o, 4'hC);
    step();

    // writes to r0 and non-writers are never inserted
    src(0, 0, 0, 0); dec(1, 1, 0, 0); step();
    dec(1, 0, 0, 0); src(0, 1, 0, 0); #1;
    chk("r0_fwd", fwd_sel_o, 0);
    chk("r0_stall", stall_o, 0);
    src(0, 0, 0, 0); dec(1, 0, 6, 0); step();
    dec(0, 1, 6, 0); step();
    dec(1, 0, 0, 0); src(6, 1, 0, 0); #1;
    chk("noins_fwd", fwd_sel_o, 0);

    // r7 in entries 0 and 2, r1 in entry 1
    src(0, 0, 0, 0);
    dec(1, 1, 7, 0); step();
    dec(1, 1, 1, 0); step();
    dec(1, 1, 7, 0); step();
    dec(1, 0, 0, 0); src(7, 1, 1, 1); #1;
    chk("young_fwd", fwd_sel_o, 4'h9);
    chk("young_stall", stall_o, 0);
    src(7, 0, 1, 1); #1;
    chk("unused_fwd", fwd_sel_o, 4'h8);
    src(7, 1, 1, 1);
    step(); chk("young_adv_fwd", fwd_sel_o, 4'hE);
    step(); chk("young_adv2_fwd", fwd_sel_o, 4'h3);
    step(); chk("young_empty_fwd", fwd_sel_o, 4'h0);

    // flush squashes the lw in entry 0
    src(0, 0, 0, 0); dec(1, 1, 9, 1); step();
    dec(1, 0, 0, 0); src(9, 1, 0, 0); #1;
    chk("flush_pre_stall", stall_o, 1);
    flush_i = 1'b1; advance_i = 1'b0; step();
    flush_i = 1'b0;
    chk("flush_stall", stall_o, 0);
    chk("flush_fwd", fwd_sel_o, 0);
    chk("flush_cnt", stall_cnt_o, 1);
    advance_i = 1'b1;
    step(); chk("flush_e2_fwd", fwd_sel_o, 0);
    step(); chk("flush_e3_fwd", fwd_sel_o, 0);

    // flush keeps older entries shifting
    src(0, 0, 0, 0);
    dec(1, 1, 10, 0); step();
    dec(1, 1, 11, 0); step();
    dec(1, 0, 0, 0); src(10, 1, 11, 1); #1;
    chk("flush2_pre_fwd", fwd_sel_o, 4'h6);
    flush_i = 1'b1; step();
    flush_i = 1'b0;
    chk("flush2_fwd", fwd_sel_o, 4'h3);
    step();

    // asynchronous reset mid-operation
    src(0, 0, 0, 0); dec(1, 1, 12, 0); step();
    dec(1, 0, 0, 0); src(12, 1, 0, 0); #1;
    chk("ar_pre_fwd", fwd_sel_o, 4'h1);
    nRST = 1'b0; #1;
    chk("ar_fwd", fwd_sel_o, 0);
    chk("ar_cnt", stall_cnt_o, 0);
    nRST = 1'b1;
    step(); chk("ar_post_fwd", fwd_sel_o, 0);
`else
    // add r4 stalls until it retires; held writer r6 is not inserted
    dec(1, 1, 4, 0); step();
    dec(1, 1, 6, 0); src(4, 1, 0, 0); #1;
    chk("r4_stall", stall_o, 1);
    chk("r4_fwd", fwd_sel_o, 0);
    advance_i = 1'b0; step();
    chk("r4_hold_stall", stall_o, 1);
    chk("r4_hold_cnt", stall_cnt_o, 0);
    advance_i = 1'b1; step();
    chk("r4_e1_stall", stall_o, 1);
    chk("r4_e1_cnt", stall_cnt_o, 1);
    step();
    chk("r4_e2_stall", stall_o, 1);
    chk("r4_e2_cnt", stall_cnt_o, 2);
    chk("r4_e2_fwd", fwd_sel_o, 0);
    step();
    chk("r4_ret_stall", stall_o, 0);
    chk("r4_ret_cnt", stall_cnt_o, 3);
    src(4, 1, 6, 1); #1;
    chk("r6_not_ins", stall_o, 0);

    // unused source and r0 never stall; flush squashes entry 0
    src(0, 0, 0, 0); dec(1, 1, 8, 0); step();
    dec(1, 0, 0, 0); src(8, 0, 0, 1); #1;
    chk("unused_stall", stall_o, 0);
    src(8, 1, 0, 0); #1;
    chk("r8_stall", stall_o, 1);
    flush_i = 1'b1; advance_i = 1'b0; step();
    flush_i = 1'b0;
    chk("flush_stall", stall_o, 0);
    chk("flush_cnt", stall_cnt_o, 3);

    // flush keeps older entries shifting
    advance_i = 1'b1; src(0, 0, 0, 0);
    dec(1, 1, 13, 0); step();
    dec(1, 1, 14, 0); step();
    dec(1, 0, 0, 0);
    flush_i = 1'b1; step();
    flush_i = 1'b0;
    src(14, 1, 0, 0); #1;
    chk("flush2_young", stall_o, 0);
    src(13, 1, 0, 0); #1;
    chk("flush2_old", stall_o, 1);

    // asynchronous reset mid-stall
    nRST = 1'b0; #1;
    chk("ar_stall", stall_o, 0);
    chk("ar_cnt", stall_cnt_o, 0);
    nRST = 1'b1;
    step();
    chk("ar_post_stall", stall_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: DEPTH, 3, number of tracked in-flight stages after decode (entry 0 = EX … entry DEPTH-1 = WB); legal range 2..8.
REQ-002 Parameter: NSRC, 2, number of decode source operands checked.
REQ-003 Parameter: RW, 5, register-select width; SW = $clog2(DEPTH+1) is the forward-select width.
REQ-004 CLK  in  1  clock, rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 advance  in  1  pipeline advances this cycle (ihit & ~dhit equivalent).
REQ-007 flush  in  1  branch/jump resolved taken; squash the youngest in-flight entry.
REQ-008 dec_valid  in  1  decode slot holds a real instruction.
REQ-009 dec_wen  in  1  decode instruction writes a register.
REQ-010 dec_wsel  in  RW  decode destination register.
REQ-011 dec_load  in  1  decode instruction is a memory load.
REQ-012 dec_src  in  NSRC*RW  packed source registers; source s occupies bits [s*RW +: RW].
REQ-013 dec_src_used  in  NSRC  source s is actually read.
REQ-014 stall  out  1  hold fetch/decode and inject a bubble.
REQ-015 fwd_sel  out  NSRC*SW  per source: 0 = register file, k = entry k-1 result.
REQ-016 stall_cnt  out  16  saturating count of stalled advancing cycles.

Function
REQ-017 Each entry SHALL hold valid, wsel[RW-1:0] and load.
REQ-018 Decode SHALL be insertable only if dec_valid & dec_wen & (dec_wsel != 0); otherwise entry 0 SHALL receive a bubble (valid = 0).
REQ-019 On a rising edge with advance=1 and flush=0, entries SHALL shift (entry i -> i+1, entry DEPTH-1 retired); entry 0 SHALL load decode if insertable and stall=0, else a bubble.
REQ-020 On a rising edge with flush=1, the shift SHALL occur regardless of advance, and new entry 0 and new entry 1 SHALL both be bubbles, so the old entry 0 is squashed; older entries shift normally.
REQ-021 With advance=0 and flush=0, all entries SHALL hold.
REQ-022 For each source s with dec_src_used[s]=1 and a nonzero register, the match SHALL be the lowest-index valid entry with an equal wsel (youngest writer wins).
REQ-023 With no match, or for register 0 or an unused source, fwd_sel[s] SHALL be 0.
REQ-024 A match at entry 0 with load=1 SHALL be a load-use hazard: stall=1 and fwd_sel[s]=0.
REQ-025 Any other match at entry i SHALL give fwd_sel[s]=i+1.
REQ-026 stall SHALL be the OR of all per-source hazards and SHALL be combinational from the current entries and decode inputs, with zero-cycle latency.
REQ-027 stall_cnt SHALL increment on each edge with stall=1 and advance=1, and SHALL hold at 16'hFFFF.
REQ-028 Simultaneous flush and stall: flush SHALL win and nothing SHALL be inserted.

Reset
REQ-029 While nRST=0, all entries SHALL be invalid, wsel=0, load=0, and stall_cnt=0; stall and fwd_sel therefore SHALL read 0.
REQ-030 An nRST assertion mid-operation SHALL discard all in-flight entries immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro SCOREBOARD_FWD_EN defined: forwarding SHALL behave per REQ-022..REQ-025.
REQ-032 Macro SCOREBOARD_FWD_EN undefined: fwd_sel SHALL be constant 0, and any match in any entry SHALL assert stall until that writer retires.

Verification (DEPTH=3, NSRC=2, SCOREBOARD_FWD_EN defined unless stated)
REQ-033 Insert add r3, advance; decode src0=r3 used -> fwd_sel[0]=1, stall=0.
REQ-034 Insert lw r5, advance; decode src1=r5 -> stall=1 for exactly one cycle, stall_cnt=1; next cycle fwd_sel[1]=2, stall=0.
REQ-035 Insert writer r0, advance; decode src0=r0 -> fwd_sel[0]=0, stall=0; entry 0 stays invalid.
REQ-036 Writers r7 in entry 2 and entry 0 (non-load); decode src0=r7 -> fwd_sel[0]=1; one more advance with a bubble -> fwd_sel[0]=2.
REQ-037 lw r9 in entry 0, flush=1 on the same edge decode reads r9 -> after the edge stall=0 and fwd_sel=0; the lw never reaches entry 2.
REQ-038 Macro undefined: add r4 inserted, decode src0=r4 -> stall=1 for 3 advancing cycles, then 0; nRST pulse mid-stall -> stall=0 and stall_cnt=0 immediately.
